// File: rtl/lc3_dispatch_ctrl.sv
// LC-3 fetch/decode sequencer: fetches an instruction, raises one handler
// request flag per opcode and runs a four-phase handshake with the handler.
module lc3_dispatch_ctrl #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        fine,
  input  logic [15:0] pc_next,
  input  logic        ld_pc_ext,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] flags,
  output logic        halted,
  output logic        error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH1   = 3'd1,
    FETCH2   = 3'd2,
    FETCH3   = 3'd3,
    DECODE   = 3'd4,
    DISPATCH = 3'd5,
    RELEASE  = 3'd6,
    STOP     = 3'd7
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  OP_RESERVED = 4'hD;
  localparam logic [15:0] HALT_INSN   = 16'hF025;

  state_t      state, state_d;
  logic [15:0] timer, timer_d;
  logic [15:0] mem_addr_d, ir_d, pc_d, flags_d;
  logic        mem_rd_d, halted_d, error_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    state_d    = state;
    timer_d    = timer;
    mem_addr_d = mem_addr;
    mem_rd_d   = mem_rd;
    ir_d       = ir;
    pc_d       = pc;
    flags_d    = flags;
    halted_d   = halted;
    error_d    = error;

    case (state)
      IDLE: if (start) state_d = FETCH1;
      FETCH1: begin
        mem_addr_d = pc;
        mem_rd_d   = 1'b1;
        state_d    = FETCH2;
      end
      FETCH2: if (mem_ready) begin
        ir_d     = mem_rdata;
        mem_rd_d = 1'b0;
        pc_d     = pc + 16'd1;
        state_d  = FETCH3;
      end
      FETCH3: state_d = DECODE;
      DECODE: begin
        if (ir[15:12] == OP_RESERVED) begin
          error_d = 1'b1;
          state_d = STOP;
        end else if (ir == HALT_INSN) begin
          halted_d = 1'b1;
          state_d  = STOP;
        end else begin
          flags_d = 16'd1 << ir[15:12];
          timer_d = '0;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        // Timer restarts so RELEASE gets its own full window.
        if (fine) begin
          flags_d = '0;
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer == TIMER_LAST) begin
          flags_d = '0;
          error_d = 1'b1;
          state_d = STOP;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      RELEASE: begin
        if (!fine) begin
          state_d = FETCH1;
        end else if (timer == TIMER_LAST) begin
          error_d = 1'b1;
          state_d = STOP;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      STOP:    state_d = STOP;
      default: state_d = IDLE;
    endcase

    // A handler PC load overrides the fetch increment.
    if (ld_pc_ext && state != IDLE && state != STOP) pc_d = pc_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir       <= '0;
      pc       <= RESET_PC;
      flags    <= '0;
      halted   <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      mem_addr <= mem_addr_d;
      mem_rd   <= mem_rd_d;
      ir       <= ir_d;
      pc       <= pc_d;
      flags    <= flags_d;
      halted   <= halted_d;
      error    <= error_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lc3_dispatch_ctrl.sv
// Self-checking bench for lc3_dispatch_ctrl: opcode table, handshake corner
// sequences and a randomized run against a transaction-level model.
module tb_lc3_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        fine = 1'b0;
  logic [15:0] pc_next = '0;
  logic        ld_pc_ext = 1'b0;
  logic [15:0] mem_addr, ir, pc, flags;
  logic        mem_rd, halted, error;
  logic [2:0]  state_dbg;

  int total  = 0;
  int passed = 0;

  lc3_dispatch_ctrl #(.TIMEOUT(64), .RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .fine(fine), .pc_next(pc_next),
    .ld_pc_ext(ld_pc_ext), .mem_addr(mem_addr), .mem_rd(mem_rd), .ir(ir),
    .pc(pc), .flags(flags), .halted(halted), .error(error),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_flags;
    logic [2:0]  exp_state;
    logic        exp_error;
    logic        exp_halted;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; mem_ready = 0; fine = 0; ld_pc_ext = 0;
    rst = 1;
    step();
    step();
    check("rst_state", state_dbg, 3'd0);
    check("rst_pc", pc, 16'h3000);
    check("rst_flags", flags, 16'h0000);
    check("rst_misc", {mem_rd, halted, error, ir, mem_addr}, 35'd0);
    rst = 0;
  endtask

  // Reset, start, serve the first fetch immediately; ends one cycle after DECODE.
  task automatic run_first(input logic [15:0] word);
    do_reset();
    start = 1; step();
    start = 0; step();
    mem_ready = 1; mem_rdata = word; step();
    mem_ready = 0; step();
    step();
  endtask

  vec_t vecs[9];
  int   n;
  logic [15:0] word, exp_pc;

  initial begin
    vecs[0] = '{16'h0E02, 16'h0001, 3'd5, 1'b0, 1'b0};
    vecs[1] = '{16'h1042, 16'h0002, 3'd5, 1'b0, 1'b0};
    vecs[2] = '{16'h5020, 16'h0020, 3'd5, 1'b0, 1'b0};
    vecs[3] = '{16'hC1C0, 16'h1000, 3'd5, 1'b0, 1'b0};
    vecs[4] = '{16'hE005, 16'h4000, 3'd5, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0100, 3'd5, 1'b0, 1'b0};
    vecs[6] = '{16'hF020, 16'h8000, 3'd5, 1'b0, 1'b0};
    vecs[7] = '{16'hD000, 16'h0000, 3'd7, 1'b1, 1'b0};
    vecs[8] = '{16'hF025, 16'h0000, 3'd7, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      run_first(vecs[i].word);
      check($sformatf("vec%0d_ir", i), ir, vecs[i].word);
      check($sformatf("vec%0d_pc", i), pc, 16'h3001);
      check($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
      check($sformatf("vec%0d_state", i), state_dbg, vecs[i].exp_state);
      check($sformatf("vec%0d_err_halt", i), {error, halted},
            {vecs[i].exp_error, vecs[i].exp_halted});
    end

    // STOP after a reserved opcode ignores start.
    run_first(16'hD000);
    start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stop_ignores_start", {state_dbg, flags}, {3'd7, 16'h0000});
    end
    start = 0;

    // BR handshake with a slow handler, then refetch from 3001.
    run_first(16'h0E02);
    step(); step();
    check("br_flag_held", flags, 16'h0001);
    fine = 1; step();
    check("br_release", {state_dbg, flags}, {3'd6, 16'h0000});
    fine = 0; step();
    check("br_back_fetch1", state_dbg, 3'd1);
    step();
    check("br_next_addr", {mem_rd, mem_addr}, {1'b1, 16'h3001});

    // ADD with fine already high on DISPATCH entry: one-cycle flag pulse.
    do_reset();
    start = 1; step();
    start = 0; step();
    mem_ready = 1; mem_rdata = 16'h1042; step();
    mem_ready = 0; step();
    fine = 1; step();
    check("add_pulse_flag", {state_dbg, flags}, {3'd5, 16'h0002});
    step();
    check("add_pulse_drop", {state_dbg, flags}, {3'd6, 16'h0000});
    fine = 0; step();
    check("add_fetch1", state_dbg, 3'd1);
    // Fastest round trip FETCH1 -> FETCH1 takes six cycles.
    mem_ready = 1; mem_rdata = 16'h1042; step();
    step();
    mem_ready = 0; step();
    step();
    fine = 1; step();
    fine = 0; step();
    check("latency6_state", state_dbg, 3'd1);
    check("latency6_pc", pc, 16'h3002);

    // DISPATCH timeout: flag held for exactly 64 cycles.
    run_first(16'h0E02);
    n = 0;
    while (flags !== 16'h0000 && n < 200) begin n++; step(); end
    check("disp_timeout_cycles", n, 64);
    check("disp_timeout_err", {state_dbg, error, flags}, {3'd7, 1'b1, 16'h0000});

    // RELEASE timeout with fine stuck high.
    run_first(16'h0E02);
    fine = 1; step();
    n = 0;
    while (state_dbg === 3'd6 && n < 200) begin n++; step(); end
    check("rel_timeout_cycles", n, 64);
    check("rel_timeout_err", {state_dbg, error}, {3'd7, 1'b1});
    fine = 0;

    // Handler PC load during DISPATCH redirects the next fetch.
    run_first(16'h0E02);
    ld_pc_ext = 1; pc_next = 16'h3010; step();
    ld_pc_ext = 0;
    check("ldpc_pc", pc, 16'h3010);
    fine = 1; step();
    fine = 0; step();
    step();
    check("ldpc_fetch_addr", mem_addr, 16'h3010);

    // PC wraps from FFFF to 0000; a coincident external load beats the increment.
    run_first(16'h0E02);
    ld_pc_ext = 1; pc_next = 16'hFFFF; step();
    ld_pc_ext = 0; fine = 1; step();
    fine = 0; step();
    step();
    check("wrap_fetch_addr", mem_addr, 16'hFFFF);
    mem_ready = 1; mem_rdata = 16'h1042; step();
    mem_ready = 0;
    check("wrap_pc", pc, 16'h0000);
    step(); step();
    fine = 1; step();
    fine = 0; step();
    step();
    mem_ready = 1; ld_pc_ext = 1; pc_next = 16'h4000; step();
    mem_ready = 0; ld_pc_ext = 0;
    check("ldpc_beats_inc", pc, 16'h4000);

    // Asynchronous reset mid-DISPATCH takes effect before the next edge.
    run_first(16'h0E02);
    check("async_pre_flags", flags, 16'h0001);
    #2 rst = 1;
    #1;
    check("async_rst", {state_dbg, pc, flags}, {3'd0, 16'h3000, 16'h0000});
    step();
    rst = 0;

    // Randomized run: bench plays memory and handlers with random delays.
    do_reset();
    start = 1; step();
    start = 0;
    exp_pc = 16'h3000;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (mem_rd !== 1'b1 && n < 20) begin n++; step(); end
      check("rnd_fetch", {mem_rd, mem_addr}, {1'b1, exp_pc});
      word = 16'($urandom);
      if (word[15:12] == 4'hD) word[15:12] = 4'h1;
      if (word == 16'hF025) word = 16'hF026;
      repeat ($urandom_range(0, 3)) step();
      mem_ready = 1; mem_rdata = word; step();
      mem_ready = 0; mem_rdata = 16'($urandom);
      exp_pc = exp_pc + 16'd1;
      n = 0;
      while (flags === 16'h0000 && n < 10) begin n++; step(); end
      check("rnd_flags", flags, 16'h0001 << word[15:12]);
      check("rnd_ir_pc", {ir, pc}, {word, exp_pc});
      if ($urandom_range(0, 1) == 1) begin
        ld_pc_ext = 1; pc_next = 16'($urandom); exp_pc = pc_next; step();
        ld_pc_ext = 0;
      end
      repeat ($urandom_range(0, 5)) step();
      check("rnd_flags_hold", {flags, pc}, {16'h0001 << word[15:12], exp_pc});
      fine = 1; step();
      check("rnd_release", {state_dbg, flags}, {3'd6, 16'h0000});
      repeat ($urandom_range(0, 4)) step();
      fine = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc3_dispatch_ctrl.md
Name: lc3_dispatch_ctrl

Overview:
- Central LC-3 sequencer: the initiator side of the per-opcode handler handshake.
- Fetches an instruction, latches IR, decodes the opcode, then raises exactly one handler request flag (BR_flag for opcode 0000, etc.).
- Holds the flag until the handler reports completion on fine, then releases the handler and returns to fetch.
- Sits between the memory interface and the instruction handler blocks, which drive the datapath muxes themselves.

Parameters:
- TIMEOUT, 64: max cycles allowed in DISPATCH or RELEASE before ERROR; 16-bit counter compare.
- RESET_PC, 16'h3000: PC load value on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory read data valid this cycle
- fine  in  1  OR of all handler completion levels
- pc_next  in  16  datapath PC value after a handler load; sampled only when ld_pc_ext=1
- ld_pc_ext  in  1  handler has loaded PC (BR/JMP/JSR/TRAP)
- mem_addr  out  16  read address (= pc during FETCH2)
- mem_rd  out  1  memory read strobe
- ir  out  16  instruction register
- pc  out  16  program counter
- flags  out  16  one-hot handler request, bit index = ir[15:12]
- halted  out  1  TRAP x25 executed
- error  out  1  reserved opcode or handshake timeout
- state_dbg  out  3  current state encoding

Behaviour:
- Reset values (async on rst=1): state IDLE, pc=RESET_PC, ir=0, flags=0, mem_rd=0, mem_addr=0, halted=0, error=0, timer=0. Reset mid-operation aborts immediately; flags drop in the same cycle reset asserts.
- States and encodings: IDLE=0, FETCH1=1, FETCH2=2, FETCH3=3, DECODE=4, DISPATCH=5, RELEASE=6, STOP=7. halted/error distinguish the two STOP causes.
- IDLE: start=1 -> FETCH1.
- FETCH1: mem_addr<=pc, mem_rd<=1 -> FETCH2.
- FETCH2: hold mem_rd=1. On mem_ready=1: ir<=mem_rdata, mem_rd<=0, pc<=pc+1 (mod 2^16; 16'hFFFF wraps to 0000) -> FETCH3. There is no timeout on memory.
- FETCH3: one settling cycle -> DECODE.
- DECODE:
  - ir[15:12]=1101 -> error<=1, STOP.
  - ir=16'hF025 -> halted<=1, STOP; no flag is raised.
  - Otherwise flags<=1<<ir[15:12], timer<=0 -> DISPATCH.
- DISPATCH: flag held high.
  - fine=1 -> flags<=0 -> RELEASE.
  - timer reaches TIMEOUT-1 without fine -> flags<=0, error<=1, STOP.
- RELEASE: wait for fine=0 (four-phase handshake); timer restarts at 0.
  - fine=0 -> FETCH1.
  - Timeout -> error, STOP.
- Any state except IDLE/STOP: ld_pc_ext=1 -> pc<=pc_next. If this coincides with the FETCH2 increment, ld_pc_ext wins.
- fine=1 already present on DECODE->DISPATCH entry: honoured on the first DISPATCH cycle (minimum flag pulse is 1 cycle).
- At most one flags bit is high at any time; flags is 0 outside DISPATCH.
- STOP is terminal until rst; start is ignored there.
- Latency with mem_ready in the first FETCH2 cycle and fine answering in 1 cycle: FETCH1 to the next FETCH1 is 6 cycles.

Test Plan:
- Reset then start=1, memory returns 16'h0E02 on the first FETCH2 cycle -> ir=0E02, pc=3001, flags=16'h0001 in DISPATCH; fine high 3 cycles later -> flags=0, RELEASE; fine low -> FETCH1 with mem_addr=3001.
- Memory returns 16'h1042 (ADD); handler drives fine=1 for 2 cycles, with fine=1 already asserted on DISPATCH entry -> flags=16'h0002 held exactly 1 cycle, then RELEASE until fine drops.
- Reserved 16'hD000 fetched -> error=1, state_dbg=7, flags never nonzero; start pulses ignored.
- fine held 0 in DISPATCH -> after 64 cycles flags=0, error=1. Repeat with fine stuck at 1 in RELEASE -> error after 64 cycles.
- Fetch 16'hF025 -> halted=1, STOP. Separately, a BR with ld_pc_ext=1, pc_next=3010 during DISPATCH -> next fetch address 3010. With pc=FFFF -> increment wraps to 0000.
- Assert rst asynchronously mid-DISPATCH (flags=0001) -> flags=0, pc=3000, state IDLE before the next clk edge.
